// File: rtl/addsub_chunked.sv
// Multi-cycle two's-complement add/sub: WIDTH-bit operands processed CHUNK bits per clock
// with a registered inter-slice carry. Define ADDSUB_SAT_EN to clamp on signed overflow.
module addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic               r_carry, r_cout, r_ovf, r_zero;
    logic [IW-1:0]      r_idx;

    logic [CHUNK-1:0]   w_a_sl, w_b_sl, w_s_sl;
    logic [CHUNK:0]     w_ext;
    logic               w_c, w_cmsb, w_last;
    logic [WIDTH-1:0]   w_full, w_final;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // r_b already holds ~b for subtract, so every slice is a plain add
    always_comb begin
        w_last = (r_idx == IW'(NCHUNK - 1));
        w_a_sl = r_a[r_idx*CHUNK +: CHUNK];
        w_b_sl = r_b[r_idx*CHUNK +: CHUNK];
        w_ext  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
        w_s_sl = w_ext[CHUNK-1:0];
        w_c    = w_ext[CHUNK];
        // carry into the slice MSB recovered from its sum bit
        w_cmsb = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_s_sl[CHUNK-1];
        w_full = r_sum;
        w_full[r_idx*CHUNK +: CHUNK] = w_s_sl;
        w_final = w_full;
`ifdef ADDSUB_SAT_EN
        if (w_last && (w_c ^ w_cmsb))
            w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= add_sub ? ~b : b;
                    r_carry <= add_sub ? ~cin : cin;
                    r_idx   <= '0;
                end
                S_RUN: begin
                    r_sum   <= w_final;
                    r_carry <= w_c;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_cout <= w_c;
                        r_ovf  <= w_c ^ w_cmsb;
                        r_zero <= (w_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_addsub_chunked.sv
// Directed bench for addsub_chunked at WIDTH=16, CHUNK=4; expectations follow ADDSUB_SAT_EN.
module tb_addsub_chunked;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, add_sub, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cout, ovf, zero;
    int          nvec = 0, nerr = 0;

    addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .add_sub(add_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // drive one operand set, return edges from accept to out_valid (-1 on timeout)
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic ts, output int lat);
        a = ta; b = tb_; cin = tc; add_sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'h0; b = 16'h0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; add_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nvec++; if ({in_ready, out_valid} !== 2'b10) begin nerr++;
            $display("FAIL reset_hs: got rdy/vld=%b%b want 10", in_ready, out_valid); end
        nvec++; if ({sum, cout, ovf, zero} !== 19'h0) begin nerr++;
            $display("FAIL reset_res: got sum=%h c=%b o=%b z=%b want all 0", sum, cout, ovf, zero); end
    endtask

    task automatic test_add_wrap();
        int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        nvec++; if (lat !== 4) begin nerr++;
            $display("FAIL add_latency: got %0d want 4", lat); end
        nvec++; if ({sum, cout, ovf, zero} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin nerr++;
            $display("FAIL add_wrap: got sum=%h c=%b o=%b z=%b want 0000 1 0 1", sum, cout, ovf, zero); end
        drain();
        nvec++; if (in_ready !== 1'b1) begin nerr++;
            $display("FAIL add_drain_rdy: got %b want 1", in_ready); end
    endtask

    task automatic test_sub();
        int lat;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        nvec++; if ({lat == 4, sum, cout, ovf, zero} !== {1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0}) begin nerr++;
            $display("FAIL sub_neg: got lat=%0d sum=%h c=%b o=%b z=%b want 4 FFFE 0 0 0", lat, sum, cout, ovf, zero); end
        drain();
        do_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat);
        nvec++; if ({sum, cout, ovf, zero} !== {16'h000E, 1'b1, 1'b0, 1'b0}) begin nerr++;
            $display("FAIL sub_borrow: got sum=%h c=%b o=%b z=%b want 000E 1 0 0", sum, cout, ovf, zero); end
        drain();
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] e_pos, e_neg;
`ifdef ADDSUB_SAT_EN
        e_pos = 16'h7FFF; e_neg = 16'h8000;
`else
        e_pos = 16'h8000; e_neg = 16'h7FFF;
`endif
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        nvec++; if ({sum, cout, ovf, zero} !== {e_pos, 1'b0, 1'b1, 1'b0}) begin nerr++;
            $display("FAIL ovf_pos: got sum=%h c=%b o=%b z=%b want %h 0 1 0", sum, cout, ovf, zero, e_pos); end
        drain();
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        nvec++; if ({sum, cout, ovf, zero} !== {e_neg, 1'b1, 1'b1, 1'b0}) begin nerr++;
            $display("FAIL ovf_neg: got sum=%h c=%b o=%b z=%b want %h 1 1 0", sum, cout, ovf, zero, e_neg); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat = -1;
        // keep in_valid high through RUN with other operands: must be ignored
        a = 16'h00FF; b = 16'h0F01; cin = 1'b1; add_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; add_sub = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        nvec++; if (lat !== 4) begin nerr++;
            $display("FAIL bp_latency: got %0d want 4", lat); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            nvec++; if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b1, 1'b0, 16'h1001, 3'b000}) begin nerr++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h c=%b o=%b z=%b want 1 0 1001 0 0 0",
                         i, out_valid, in_ready, sum, cout, ovf, zero); end
        end
        in_valid = 1'b0;
        drain();
        nvec++; if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 16'h1001}) begin nerr++;
            $display("FAIL bp_release: got rdy=%b vld=%b sum=%h want 1 0 1001", in_ready, out_valid, sum); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; add_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++; if ({in_ready, out_valid, sum, cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin nerr++;
            $display("FAIL rst_mid: got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want 1 0 0000 0 0 0",
                     in_ready, out_valid, sum, cout, ovf, zero); end
        do_op(16'h0102, 16'h0304, 1'b0, 1'b0, lat);
        nvec++; if ({lat == 4, sum, cout, ovf, zero} !== {1'b1, 16'h0406, 3'b000}) begin nerr++;
            $display("FAIL rst_recover: got lat=%0d sum=%h c=%b o=%b z=%b want 4 0406 0 0 0", lat, sum, cout, ovf, zero); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3] = '{16'h1234, 16'h1000, 16'hABCD};
        logic [15:0] vb [3] = '{16'h1111, 16'h0001, 16'h0003};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic        vs [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] ve [3] = '{16'h2345, 16'h0FFF, 16'hABD1};
        int k = 0, r = 0, cyc = 0;
        int t [3];
        logic rdy;
        a = va[0]; b = vb[0]; cin = vc[0]; add_sub = vs[0];
        in_valid = 1'b1; out_ready = 1'b1;
        while (r < 3 && cyc < 60) begin
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && in_valid) begin
                k++;
                if (k < 3) begin a = va[k]; b = vb[k]; cin = vc[k]; add_sub = vs[k]; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                t[r] = cyc;
                nvec++; if (sum !== ve[r]) begin nerr++;
                    $display("FAIL b2b_res%0d: got %h want %h", r, sum, ve[r]); end
                r++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        nvec++; if (r !== 3) begin nerr++;
            $display("FAIL b2b_count: got %0d results want 3", r); end
        else begin
            nvec++; if ((t[1] - t[0]) !== 6 || (t[2] - t[1]) !== 6) begin nerr++;
                $display("FAIL b2b_spacing: got %0d,%0d want 6,6", t[1] - t[0], t[2] - t[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
